// File: rtl/rr_output_arbiter3_if.sv
// Handshake bundle between three router input channels, one output-port arbiter
// and the neighbouring router's receive side.
interface rr_output_arbiter3_if #(
  parameter int DATA_PACKET_SIZE = 32
);
  logic [2:0]                  req;
  logic [DATA_PACKET_SIZE-1:0] in_data1;
  logic [DATA_PACKET_SIZE-1:0] in_data2;
  logic [DATA_PACKET_SIZE-1:0] in_data3;
  logic [2:0]                  pop;
  logic [DATA_PACKET_SIZE-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [1:0]                  select;

  modport master (
    output req, in_data1, in_data2, in_data3, out_ready,
    input  pop, out_data, out_valid, select
  );

  modport slave (
    input  req, in_data1, in_data2, in_data3, out_ready,
    output pop, out_data, out_valid, select
  );
endinterface

// File: rtl/rr_output_arbiter3.sv
// Round-robin output-port arbiter: shares one router output between west/east/north,
// with bounded bursts per owner and a one-entry registered valid/ready output stage.
module rr_output_arbiter3 #(
  parameter int DATA_PACKET_SIZE = 32,
  parameter int BURST_LEN        = 4
) (
  input logic              clk_rtr,
  input logic              reset,
  rr_output_arbiter3_if.slave bus
);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [0:0]                  state;
  logic [1:0]                  owner;
  logic [1:0]                  ptr;
  logic [CW-1:0]               burst_cnt;
  logic [DATA_PACKET_SIZE-1:0] out_data;
  logic                        out_valid;

  logic                        slot_free;
  logic                        grant;
  logic                        hold;
  logic [1:0]                  start;
  logic [1:0]                  c1;
  logic [1:0]                  c2;
  logic [1:0]                  win;
  logic [DATA_PACKET_SIZE-1:0] win_data;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign slot_free = !out_valid || bus.out_ready;
  assign grant     = slot_free && (|bus.req) && !reset;
  assign hold      = (state == OWN) && bus.req[owner] && (burst_cnt < CNT_MAX);

  // While owned, the scan starts after the owner, so an exhausted or released
  // owner is considered last.
  assign start = (state == OWN) ? inc3(owner) : ptr;
  assign c1    = inc3(start);
  assign c2    = inc3(c1);

  always_comb begin
    win = c2;
    if (hold)                  win = owner;
    else if (bus.req[start])   win = start;
    else if (bus.req[c1])      win = c1;
  end

  always_comb begin
    bus.pop = 3'b000;
    if (grant) bus.pop[win] = 1'b1;
  end

  always_comb begin
    case (win)
      2'd0:    win_data = bus.in_data1;
      2'd1:    win_data = bus.in_data2;
      default: win_data = bus.in_data3;
    endcase
  end

  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (grant) begin
      out_data  <= win_data;
      out_valid <= 1'b1;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_rtr or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd0;
      ptr       <= 2'd0;
      burst_cnt <= '0;
    end else if (slot_free) begin
      if (state == IDLE) begin
        if (grant) begin
          state     <= OWN;
          owner     <= win;
          burst_cnt <= '0;
        end
      end else if (grant) begin
        if (win == owner) begin
          // Same owner again: either still inside its burst, or sole requester
          // after exhausting it, which starts a fresh burst.
          burst_cnt <= hold ? burst_cnt + 1'b1 : '0;
        end else begin
          owner     <= win;
          burst_cnt <= '0;
          ptr       <= inc3(owner);
        end
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
        ptr       <= inc3(owner);
      end
    end
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.select    = (state == OWN) ? owner : 2'd3;
endmodule
